// File: rtl/lsu_axi_lite.sv
// lsu_axi_lite
// Load/store unit that converts one data-memory access from the execute
// stage into an AXI-lite master transaction. It aligns byte lanes, builds
// the write strobe, and sign- or zero-extends load data. req_ready is held
// low while an access is in flight, which stalls the core.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready      request handshake from execute
//   req_we                   1 = store, 0 = load
//   req_addr                 byte address
//   req_memop                size/extension code (000 b, 001 h, 010 w, 011 d,
//                            100 bu, 101 hu, 110 wu, 111 reserved)
//   req_wdata                right-justified store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata               extended load data (0 for stores and errors)
//   resp_err                 misaligned, reserved memop or non-OKAY response
//   AR/R/AW/W/B              AXI-lite master channels
module lsu_axi_lite #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_memop,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [7:0]        WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, DONE} state_t;

  state_t      state;
  logic [2:0]  addr_lo_q;
  logic [2:0]  memop_q;
  logic        aw_done;
  logic        w_done;

  logic [2:0]        size_mask;
  logic [7:0]        strb_base;
  logic              misaligned;
  logic              reserved;
  logic [7:0]        wstrb_next;
  logic [DATA_W-1:0] wdata_next;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] load_data;
  logic              aw_now;
  logic              w_now;

  // Request decode: alignment check, strobe and lane placement are worked
  // out from the incoming request so they can be latched on accept.
  always_comb begin
    size_mask = 3'b000;
    strb_base = 8'h01;
    case (req_memop[1:0])
      2'd0: begin size_mask = 3'b000; strb_base = 8'h01; end
      2'd1: begin size_mask = 3'b001; strb_base = 8'h03; end
      2'd2: begin size_mask = 3'b011; strb_base = 8'h0F; end
      default: begin size_mask = 3'b111; strb_base = 8'hFF; end
    endcase
    misaligned = |(req_addr[2:0] & size_mask);
    reserved   = (req_memop == 3'b111);
    wstrb_next = strb_base << req_addr[2:0];
    wdata_next = req_wdata << {req_addr[2:0], 3'b000};
    bus_addr   = {req_addr[ADDR_W-1:3], 3'b000};
  end

  // Load path: bring the addressed byte lane down to bit 0, then extend.
  // memop[2] selects zero extension; the doubleword case needs none.
  always_comb begin
    rd_shift  = RDATA >> {addr_lo_q, 3'b000};
    load_data = '0;
    case (memop_q[1:0])
      2'd0: load_data = memop_q[2] ? {56'b0, rd_shift[7:0]}
                                   : {{56{rd_shift[7]}}, rd_shift[7:0]};
      2'd1: load_data = memop_q[2] ? {48'b0, rd_shift[15:0]}
                                   : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'd2: load_data = memop_q[2] ? {32'b0, rd_shift[31:0]}
                                   : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: load_data = rd_shift;
    endcase
  end

  // Write channel completion, counting a handshake happening this cycle.
  always_comb begin
    aw_now = aw_done | (AWVALID & AWREADY);
    w_now  = w_done  | (WVALID & WREADY);
  end

  // Main FSM. Every output is a register so nothing on the AXI inputs can
  // reach an AXI output combinationally; reset drops all VALID/READY at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_lo_q  <= 3'b000;
      memop_q    <= 3'b000;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      ARADDR     <= '0;
      ARVALID    <= 1'b0;
      RREADY     <= 1'b0;
      AWADDR     <= '0;
      AWVALID    <= 1'b0;
      WDATA      <= '0;
      WSTRB      <= 8'h00;
      WVALID     <= 1'b0;
      BREADY     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr_lo_q <= req_addr[2:0];
            memop_q   <= req_memop;
            if (misaligned || reserved) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we) begin
              state   <= WR;
              AWADDR  <= bus_addr;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              WDATA   <= wdata_next;
              WSTRB   <= wstrb_next;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= RD_A;
              ARADDR  <= bus_addr;
              ARVALID <= 1'b1;
            end
          end
        end
        RD_A: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_D;
          end
        end
        RD_D: begin
          if (RVALID) begin
            RREADY     <= 1'b0;
            state      <= DONE;
            resp_valid <= 1'b1;
            if (RRESP != 2'b00) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              resp_err   <= 1'b0;
              resp_rdata <= load_data;
            end
          end
        end
        WR: begin
          if (AWVALID && AWREADY) AWVALID <= 1'b0;
          if (WVALID && WREADY)   WVALID  <= 1'b0;
          aw_done <= aw_now;
          w_done  <= w_now;
          if (aw_now && w_now) begin
            state   <= WR_B;
            BREADY  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        WR_B: begin
          if (BVALID) begin
            BREADY     <= 1'b0;
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_err   <= (BRESP != 2'b00);
            resp_rdata <= '0;
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_lite.sv
// tb_lsu_axi_lite
// Directed bench for lsu_axi_lite. A small AXI-lite slave answers with
// programmable wait states and responses; a monitor records handshakes,
// captured bus values and response timing. Expected values are hand-derived.
module tb_lsu_axi_lite;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [2:0]  req_memop;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [63:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  lsu_axi_lite #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_memop(req_memop), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Slave configuration, written only by the stimulus process.
  int          ar_delay = 0;
  int          aw_delay = 0;
  logic        r_stall = 1'b0;
  logic [63:0] rdata_model = '0;
  logic [1:0]  rresp_model = 2'b00;
  logic [1:0]  bresp_model = 2'b00;

  // Slave handshake state and monitor records, written only by the monitor.
  int          cycle = 0;
  int          acc_cycle = 0;
  int          resp_cycle = 0;
  int          resp_cnt = 0;
  int          arvalid_cycles = 0;
  int          awvalid_cycles = 0;
  int          wvalid_cycles = 0;
  int          aw_hs = 0;
  int          b_hs = 0;
  int          awaddr_changes = 0;
  logic        pending_r = 1'b0;
  logic        pending_b = 1'b0;
  logic        aw_got = 1'b0;
  logic        w_got = 1'b0;
  logic        aw_hold = 1'b0;
  logic [63:0] aw_hold_addr = '0;
  logic [63:0] cap_rdata = '0;
  logic        cap_err = 1'b0;
  logic [63:0] cap_araddr = '0;
  logic [63:0] cap_awaddr = '0;
  logic [63:0] cap_wdata = '0;
  logic [7:0]  cap_wstrb = '0;

  int ar_wait = 0;
  int aw_wait = 0;
  int resp_before = 0;

  // Slave outputs change on the falling edge, away from the DUT's sampling edge.
  always @(negedge clk) begin
    if (!rst) begin
      ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
      RVALID = 1'b0; BVALID = 1'b0; ar_wait = 0; aw_wait = 0;
    end else begin
      if (ARVALID) begin ARREADY = (ar_wait >= ar_delay); ar_wait++; end
      else begin ARREADY = 1'b0; ar_wait = 0; end
      if (AWVALID) begin AWREADY = (aw_wait >= aw_delay); aw_wait++; end
      else begin AWREADY = 1'b0; aw_wait = 0; end
      WREADY = WVALID;
      RVALID = pending_r && !r_stall;
      BVALID = pending_b;
    end
    RDATA = rdata_model;
    RRESP = rresp_model;
    BRESP = bresp_model;
  end

  // Monitor: samples everything on the rising edge.
  always @(posedge clk) begin
    if (req_valid && req_ready) acc_cycle = cycle;
    if (resp_valid) begin
      resp_cnt++; resp_cycle = cycle; cap_rdata = resp_rdata; cap_err = resp_err;
    end
    if (ARVALID) arvalid_cycles++;
    if (AWVALID) awvalid_cycles++;
    if (WVALID)  wvalid_cycles++;
    if (ARVALID && ARREADY) cap_araddr = ARADDR;
    if (AWVALID) begin
      if (aw_hold && AWADDR != aw_hold_addr) awaddr_changes++;
      aw_hold = !AWREADY;
      aw_hold_addr = AWADDR;
    end else begin
      aw_hold = 1'b0;
    end
    if (!rst) begin
      pending_r = 1'b0; pending_b = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    end else begin
      if (ARVALID && ARREADY) pending_r = 1'b1;
      if (RVALID && RREADY) pending_r = 1'b0;
      if (BVALID && BREADY) begin b_hs++; pending_b = 1'b0; end
      if (AWVALID && AWREADY) begin aw_hs++; cap_awaddr = AWADDR; end
      if (WVALID && WREADY) begin cap_wdata = WDATA; cap_wstrb = WSTRB; end
      if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY))) begin
        pending_b = 1'b1; aw_got = 1'b0; w_got = 1'b0;
      end else begin
        aw_got = aw_got || (AWVALID && AWREADY);
        w_got  = w_got  || (WVALID && WREADY);
      end
    end
    cycle++;
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Present one request and hold it until the accepting edge.
  task automatic applyStimulus(input logic we, input logic [63:0] addr,
                               input logic [2:0] memop, input logic [63:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) checkOutput("req_ready_timeout", 64'd0, 64'd1);
    resp_before = resp_cnt;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_memop = memop; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic waitResp(input string tag);
    int n;
    n = 0;
    while (resp_cnt == resp_before && n < 100) begin @(negedge clk); n++; end
    if (resp_cnt == resp_before) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  int snap_ar;
  int snap_aw;
  int snap_w;
  int snap_awhs;
  int snap_b;
  int snap_chg;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_memop = '0; req_wdata = '0;
    ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; RVALID = 1'b0; BVALID = 1'b0;
    RDATA = '0; RRESP = 2'b00; BRESP = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", {56'd0, ARVALID, RREADY, AWVALID, WVALID, BREADY,
                               resp_valid, resp_err, req_ready}, 64'd0);
    checkOutput("reset_rdata", resp_rdata, 64'd0);
    checkOutput("reset_addr", ARADDR | AWADDR, 64'd0);
    checkOutput("reset_wlane", {WDATA[55:0], WSTRB}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // lb, negative byte in lane 3
    rdata_model = 64'h00000000_F0000000;
    applyStimulus(1'b0, 64'h80000003, 3'b000, 64'd0);
    waitResp("lb");
    checkOutput("lb_rdata", cap_rdata, 64'hFFFFFFFF_FFFFFFF0);
    checkOutput("lb_err", {63'd0, cap_err}, 64'd0);
    checkOutput("lb_latency", resp_cycle - acc_cycle, 64'd3);
    checkOutput("lb_araddr", cap_araddr, 64'h80000000);

    // lh, sign bit set in lane 2
    rdata_model = 64'h00000000_80010000;
    applyStimulus(1'b0, 64'h80000002, 3'b001, 64'd0);
    waitResp("lh");
    checkOutput("lh_rdata", cap_rdata, 64'hFFFFFFFF_FFFF8001);

    // sh into the top halfword
    applyStimulus(1'b1, 64'h80000006, 3'b001, 64'h00000000_0000ABCD);
    waitResp("sh");
    checkOutput("sh_awaddr", cap_awaddr, 64'h80000000);
    checkOutput("sh_wstrb", {56'd0, cap_wstrb}, 64'h00000000_000000C0);
    checkOutput("sh_wdata_hi", {48'd0, cap_wdata[63:48]}, 64'h00000000_0000ABCD);
    checkOutput("sh_err", {63'd0, cap_err}, 64'd0);
    checkOutput("sh_latency", resp_cycle - acc_cycle, 64'd3);

    // sd with AWREADY stalled 4 cycles, WREADY immediate
    aw_delay = 4;
    snap_aw = awvalid_cycles; snap_w = wvalid_cycles; snap_awhs = aw_hs;
    snap_b = b_hs; snap_chg = awaddr_changes;
    applyStimulus(1'b1, 64'h80000010, 3'b011, 64'h11223344_55667788);
    waitResp("sd");
    repeat (3) @(negedge clk);
    aw_delay = 0;
    checkOutput("sd_wvalid_cycles", wvalid_cycles - snap_w, 64'd1);
    checkOutput("sd_awvalid_cycles", awvalid_cycles - snap_aw, 64'd5);
    checkOutput("sd_aw_stable", awaddr_changes - snap_chg, 64'd0);
    checkOutput("sd_aw_hs", aw_hs - snap_awhs, 64'd1);
    checkOutput("sd_b_hs", b_hs - snap_b, 64'd1);
    checkOutput("sd_resp_count", resp_cnt - resp_before, 64'd1);
    checkOutput("sd_wdata", cap_wdata, 64'h11223344_55667788);
    checkOutput("sd_wstrb", {56'd0, cap_wstrb}, 64'h00000000_000000FF);
    checkOutput("sd_latency", resp_cycle - acc_cycle, 64'd7);

    // sw with SLVERR write response
    bresp_model = 2'b10;
    applyStimulus(1'b1, 64'h80000004, 3'b010, 64'h00000000_12345678);
    waitResp("sw_slverr");
    bresp_model = 2'b00;
    checkOutput("sw_wstrb", {56'd0, cap_wstrb}, 64'h00000000_000000F0);
    checkOutput("sw_wdata_hi", {32'd0, cap_wdata[63:32]}, 64'h00000000_12345678);
    checkOutput("sw_err", {63'd0, cap_err}, 64'd1);

    // misaligned lw: no bus traffic, error after one cycle
    snap_ar = arvalid_cycles;
    applyStimulus(1'b0, 64'h80000002, 3'b010, 64'd0);
    waitResp("lw_mis");
    checkOutput("lw_mis_err", {63'd0, cap_err}, 64'd1);
    checkOutput("lw_mis_latency", resp_cycle - acc_cycle, 64'd1);
    checkOutput("lw_mis_arvalid", arvalid_cycles - snap_ar, 64'd0);
    checkOutput("lw_mis_rdata", cap_rdata, 64'd0);

    // reserved memop at an aligned address
    snap_ar = arvalid_cycles;
    applyStimulus(1'b0, 64'h80000008, 3'b111, 64'd0);
    waitResp("reserved");
    checkOutput("reserved_err", {63'd0, cap_err}, 64'd1);
    checkOutput("reserved_arvalid", arvalid_cycles - snap_ar, 64'd0);

    // lwu of upper word, zero-extended
    rdata_model = 64'h80000000_00000000;
    applyStimulus(1'b0, 64'h80000004, 3'b110, 64'd0);
    waitResp("lwu");
    checkOutput("lwu_rdata", cap_rdata, 64'h00000000_80000000);
    checkOutput("lwu_err", {63'd0, cap_err}, 64'd0);

    // ld with SLVERR read response
    rdata_model = 64'h01234567_89ABCDEF;
    rresp_model = 2'b10;
    applyStimulus(1'b0, 64'h80000008, 3'b011, 64'd0);
    waitResp("ld_slverr");
    rresp_model = 2'b00;
    checkOutput("ld_slverr_err", {63'd0, cap_err}, 64'd1);
    checkOutput("ld_slverr_rdata", cap_rdata, 64'd0);

    // reset asserted while waiting in RD_D
    r_stall = 1'b1;
    applyStimulus(1'b0, 64'h80000018, 3'b011, 64'd0);
    begin
      int n;
      n = 0;
      while (!RREADY && n < 20) begin @(negedge clk); n++; end
      checkOutput("rst_mid_reach_rd_d", {63'd0, RREADY}, 64'd1);
    end
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_mid_async", {62'd0, ARVALID, RREADY}, 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("rst_mid_no_resp", resp_cnt - resp_before, 64'd0);
    rst = 1'b1;
    r_stall = 1'b0;

    rdata_model = 64'hDEADBEEF_CAFEF00D;
    applyStimulus(1'b0, 64'h80000018, 3'b011, 64'd0);
    waitResp("ld_after_rst");
    checkOutput("ld_after_rst_rdata", cap_rdata, 64'hDEADBEEF_CAFEF00D);
    checkOutput("ld_after_rst_err", {63'd0, cap_err}, 64'd0);
    checkOutput("ld_after_rst_latency", resp_cycle - acc_cycle, 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/lsu_axi_lite.md
# lsu_axi_lite

Load/store unit that turns the core's single data-memory access into AXI-lite master transactions. It sits between the execute stage (ALU result as address, rs2 as store data, MemOP/MemWr from the decoder) and the data port of the AXI-lite RAM, in place of the combinational DPI data memory. It also performs the byte-lane alignment, write-strobe generation and load sign/zero extension. While an access is in flight it stalls the core by holding `req_ready` low.

## Interface
Parameters:
- `ADDR_W`, 64: address width (matches `MemAddrBus`).
- `DATA_W`, 64: AXI data width (matches `MemDataBus`); fixed at 64, 8 strobe bits.

Ports (reset is asynchronous and active-low):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `req_valid`  in  1  access request from execute.
- `req_ready`  out  1  high only in IDLE; request accepted on `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  byte address.
- `req_memop`  in  3  access size and extension: 000 lb/sb, 001 lh/sh, 010 lw/sw, 011 ld/sd, 100 lbu, 101 lhu, 110 lwu, 111 reserved.
- `req_wdata`  in  64  store data, right-justified.
- `resp_valid`  out  1  one-cycle pulse when the access completes.
- `resp_rdata`  out  64  extended load data; 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`: misaligned access, reserved memop, or non-OKAY RESP.
- AXI-lite master signals, full AR/R/AW/W/B set with standard meanings:
  - Read address and data: `ARADDR`/`ARVALID`/`ARREADY`, `RDATA`/`RRESP`/`RVALID`/`RREADY`.
  - Write address and data: `AWADDR`/`AWVALID`/`AWREADY`, `WDATA`/`WSTRB[7:0]`/`WVALID`/`WREADY`.
  - Write response: `BRESP`/`BVALID`/`BREADY`.

## Operation
- FSM states: IDLE, RD_A, RD_D, WR, WR_B, DONE.
- IDLE behaviour:
  - On accept, latch `addr`, `memop`, `we`, `wdata`.
  - Misaligned or reserved memop goes directly to DONE with err=1, issuing no bus traffic.
  - A load goes to RD_A; a store goes to WR.
- Alignment rule: size = 1 << memop[1:0] bytes; the address must be a multiple of size.
- Bus address: `ARADDR`/`AWADDR` = addr with bits [2:0] cleared.
- RD_A: `ARVALID`=1 with a stable address until `ARREADY`, then RD_D.
- RD_D: `RREADY`=1. On `RVALID`:
  - Shift `RDATA` right by 8*addr[2:0] and truncate to size.
  - Sign-extend when memop[2]=0, zero-extend when memop[2]=1.
  - `RRESP`≠00 sets err and forces the data to 0. Then DONE.
- WR:
  - `AWVALID` and `WVALID` assert together.
  - Each drops independently after its own handshake; tracked by `aw_done`/`w_done` flags.
  - Move to WR_B when both are done, including the case where both complete in the same cycle.
- Write lanes:
  - `WSTRB` = ((1<<size)-1) << addr[2:0].
  - `WDATA` = wdata << 8*addr[2:0]; lanes outside the strobe are don't-care and are driven by the shifted value.
- WR_B: `BREADY`=1; on `BVALID`, `BRESP`≠00 sets err; then DONE.
- DONE: `resp_valid`=1 for exactly one cycle, then IDLE.
- Reset values (all outputs): `req_ready`=0 while `rst` is low; `resp_valid`, `resp_err`, every AXI VALID/READY = 0; `resp_rdata`=0; address/data/strobe outputs = 0.
- Reset mid-operation: asynchronously abandons the transaction, drops all VALID/READY, FSM goes to IDLE; no response is produced.

## Timing
- All outputs are registered or decoded from state; no combinational path from AXI inputs to AXI outputs.
- Minimum load latency with ARREADY=1 and RVALID arriving in the cycle after AR:
  - Accept at cycle 0, AR handshake at 1, R handshake at 2, `resp_valid` at 3.
- Minimum store latency with AWREADY=WREADY=1 and BVALID in the next cycle:
  - Accept at 0, AW+W at 1, B at 2, `resp_valid` at 3.
- Error without bus traffic: accept at 0, `resp_valid` at 1.
- Slave wait states extend RD_A/RD_D/WR/WR_B without bound; no timeout.
- Back-to-back: `req_ready` returns high the cycle after DONE, so the earliest next accept is the cycle after `resp_valid`.
- RDATA/BRESP are sampled only on the handshake cycle; values outside it are ignored.

## Test plan
- Load `lb` at addr 0x80000003, RDATA=0x00000000_F0000000 (byte 3 = 0xF0) → resp_rdata=0xFFFFFFFF_FFFFFFF0, err=0, `resp_valid` at cycle 3.
- Store `sh` of wdata=0xABCD at 0x80000006 → AWADDR=0x80000000, WSTRB=0xC0, WDATA[63:48]=0xABCD; resp_err=0.
- Store `sd` with AWREADY held 4 cycles and WREADY immediate → WVALID drops after 1 cycle, AWVALID holds with a stable address, exactly one B accepted, one `resp_valid`.
- Misaligned `lw` at 0x80000002 → no ARVALID ever asserted, `resp_valid`=1 with err=1 at cycle 1; `lwu` at 0x80000004, RDATA=0x80000000_00000000 → 0x00000000_80000000.
- RRESP=10 on an `ld` → resp_err=1, resp_rdata=0.
- `rst` driven low while in RD_D → ARVALID/RREADY are 0 immediately (before the next clock edge), no `resp_valid`; after release, a new `ld` completes normally.
